// File: rtl/sram_cfg_bank.sv
// sram_cfg_bank: configuration SRAM bank for the FPGA fabric.
//
// The bitstream loader streams DEPTH words into the array through a valid/ready
// handshake, using an auto-incrementing address. When the last word is accepted
// the bank enters run mode. In run mode, configuration consumers read through a
// registered, enabled read port, and a user write port may patch words. If a
// read and a write hit the same address in one cycle, the read returns the old
// contents (read-first).
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset (the array itself is not cleared)
//   cfg_start  pulse: begin or restart a full load at address 0
//   cfg_valid  cfg_data is valid
//   cfg_data   bitstream word
//   cfg_ready  bank accepts a cfg word this cycle (high only while loading)
//   cfg_done   level: bank fully loaded, run mode
//   raddr      read address
//   rd_en      read enable (effective in run mode only)
//   rdata      registered read data, 1-cycle latency
//   waddr      user write address
//   wdata      user write data
//   we         user write enable (effective in run mode only)
//   par_err    (SRAM_CFG_PARITY_EN only) parity mismatch of the last read word
//
// Optional feature: define SRAM_CFG_PARITY_EN to store one even-parity bit per
// word and to add the registered par_err output.

module sram_cfg_bank #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  output logic                  cfg_ready,
  output logic                  cfg_done,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we
`ifdef SRAM_CFG_PARITY_EN
  ,
  output logic                  par_err
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(Depth - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  cfg_done_q, cfg_done_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  accept;
  logic                  load_we;
  logic                  user_we;
  logic                  rd_fire;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // --------------------------------------------------------------------------
  // Load / run control FSM
  // --------------------------------------------------------------------------

  // A handshake happens only while loading; cfg_ready_q is high exactly then.
  assign accept = (state_q == StLoad) && cfg_valid && cfg_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        if (cfg_start) begin
          // Restart wins: a word presented in the same cycle is dropped.
          cnt_d = '0;
        end else if (accept) begin
          load_we = 1'b1;
          if (cnt_q == LastAddr) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      StRun: begin
        if (cfg_start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs are registered from the next state, so they follow the
  // state register one cycle after the deciding edge.
  assign cfg_ready_d = (state_d == StLoad);
  assign cfg_done_d  = (state_d == StRun);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_done  = cfg_done_q;

  // --------------------------------------------------------------------------
  // Storage array
  // --------------------------------------------------------------------------

  // The loader owns the array during a load; user writes only land in run mode.
  assign user_we = (state_q == StRun) && we;
  assign rd_fire = (state_q == StRun) && rd_en;

  // No reset on the array: contents survive rst_n. Writes are blocked while
  // rst_n is low so a reset cycle cannot commit a half-finished handshake.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (load_we) begin
        mem[cnt_q] <= cfg_data;
      end else if (user_we) begin
        mem[waddr] <= wdata;
      end
    end
  end

  // Read-first on collision falls out of the non-blocking array update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_fire) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

`ifdef SRAM_CFG_PARITY_EN
  // --------------------------------------------------------------------------
  // Parity side array: one even-parity bit per word, checked on read.
  // --------------------------------------------------------------------------
  logic             mem_par [Depth];
  logic             par_err_q;
  logic             load_par;
  logic             user_par;

  assign load_par = ^cfg_data;
  assign user_par = ^wdata;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (load_we) begin
        mem_par[cnt_q] <= load_par;
      end else if (user_we) begin
        mem_par[waddr] <= user_par;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (rd_fire) begin
      par_err_q <= (^mem[raddr]) ^ mem_par[raddr];
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_sram_cfg_bank.sv
// Directed self-checking bench for sram_cfg_bank (ADDR_WIDTH=4, DATA_WIDTH=8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// so each value seen reflects the edge just taken.

module tb_sram_cfg_bank;

  logic       clk;
  logic       rst_n;
  logic       cfg_start;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       cfg_done;
  logic [3:0] raddr;
  logic       rd_en;
  logic [7:0] rdata;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic       we;
`ifdef SRAM_CFG_PARITY_EN
  logic       par_err;
`endif

  int n_checks;
  int n_pass;

  sram_cfg_bank #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_data (cfg_data),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .raddr    (raddr),
    .rd_en    (rd_en),
    .rdata    (rdata),
    .waddr    (waddr),
    .wdata    (wdata),
    .we       (we)
`ifdef SRAM_CFG_PARITY_EN
    ,
    .par_err  (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present n words base, base+1, ...; with gaps, a valid-low cycle carrying
  // junk data precedes each word.
  task automatic load_words(input logic [7:0] base, input bit gaps, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        cfg_valid = 1'b0;
        cfg_data  = 8'hFF;
        step();
      end
      cfg_valid = 1'b1;
      cfg_data  = base + 8'(i);
      step();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    rd_en = 1'b1;
    raddr = a;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    raddr = '0; rd_en = 1'b0; waddr = '0; wdata = '0; we = 1'b0;
    step();
    step();
    n_checks++;
    if (cfg_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", cfg_ready);
    else n_pass++;
    n_checks++;
    if (cfg_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", cfg_done);
    else n_pass++;
    n_checks++;
    if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h expected 00", rdata);
    else n_pass++;
    rst_n = 1'b1;
    do_read(4'd3);
    n_checks++;
    if (rdata !== 8'h00) $display("FAIL idle_read: got %h expected 00", rdata);
    else n_pass++;
    n_checks++;
    if (cfg_ready !== 1'b0) $display("FAIL idle_ready: got %b expected 0", cfg_ready);
    else n_pass++;
  endtask

  task automatic test_full_load();
    start_load();
    n_checks++;
    if (cfg_ready !== 1'b1) $display("FAIL load_ready: got %b expected 1", cfg_ready);
    else n_pass++;
    load_words(8'h10, 1'b0, 15);
    n_checks++;
    if (cfg_done !== 1'b0) $display("FAIL done_early: got %b expected 0", cfg_done);
    else n_pass++;
    load_words(8'h1F, 1'b0, 1);
    n_checks++;
    if (cfg_done !== 1'b1) $display("FAIL done_after_last: got %b expected 1", cfg_done);
    else n_pass++;
    n_checks++;
    if (cfg_ready !== 1'b0) $display("FAIL ready_after_last: got %b expected 0", cfg_ready);
    else n_pass++;
    do_read(4'd5);
    n_checks++;
    if (rdata !== 8'h15) $display("FAIL read5: got %h expected 15", rdata);
    else n_pass++;
    raddr = 4'd9;
    step();
    n_checks++;
    if (rdata !== 8'h15) $display("FAIL rd_en_low_hold: got %h expected 15", rdata);
    else n_pass++;
  endtask

  task automatic test_gaps();
    start_load();
    load_words(8'h10, 1'b1, 15);
    n_checks++;
    if (cfg_done !== 1'b0) $display("FAIL gap_done_early: got %b expected 0", cfg_done);
    else n_pass++;
    load_words(8'h1F, 1'b1, 1);
    n_checks++;
    if (cfg_done !== 1'b1) $display("FAIL gap_done: got %b expected 1", cfg_done);
    else n_pass++;
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a));
      n_checks++;
      if (rdata !== 8'h10 + 8'(a))
        $display("FAIL gap_read[%0d]: got %h expected %h", a, rdata, 8'h10 + 8'(a));
      else n_pass++;
    end
  endtask

  task automatic test_restart();
    start_load();
    n_checks++;
    if (cfg_done !== 1'b0) $display("FAIL run_restart_done: got %b expected 0", cfg_done);
    else n_pass++;
    load_words(8'h50, 1'b0, 6);
    // Restart with a word presented in the same cycle: that word is dropped.
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'hEE;
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_ready !== 1'b1) $display("FAIL restart_ready: got %b expected 1", cfg_ready);
    else n_pass++;
    load_words(8'hA0, 1'b0, 16);
    n_checks++;
    if (cfg_done !== 1'b1) $display("FAIL restart_done: got %b expected 1", cfg_done);
    else n_pass++;
    do_read(4'd0);
    n_checks++;
    if (rdata !== 8'hA0) $display("FAIL restart_mem0: got %h expected a0", rdata);
    else n_pass++;
    do_read(4'd1);
    n_checks++;
    if (rdata !== 8'hA1) $display("FAIL restart_mem1: got %h expected a1", rdata);
    else n_pass++;
    do_read(4'd15);
    n_checks++;
    if (rdata !== 8'hAF) $display("FAIL restart_mem15: got %h expected af", rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    start_load();
    load_words(8'hC0, 1'b0, 8);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if (cfg_done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", cfg_done);
    else n_pass++;
    n_checks++;
    if (cfg_ready !== 1'b0) $display("FAIL midrst_ready: got %b expected 0", cfg_ready);
    else n_pass++;
    n_checks++;
    if (rdata !== 8'h00) $display("FAIL midrst_rdata: got %h expected 00", rdata);
    else n_pass++;
    // Idle: valid words are not taken and no load resumes.
    cfg_valid = 1'b1;
    cfg_data  = 8'h33;
    step();
    step();
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_ready !== 1'b0 || cfg_done !== 1'b0)
      $display("FAIL midrst_idle: got ready=%b done=%b expected ready=0 done=0",
               cfg_ready, cfg_done);
    else n_pass++;
    do_read(4'd0);
    n_checks++;
    if (rdata !== 8'h00) $display("FAIL midrst_idle_read: got %h expected 00", rdata);
    else n_pass++;
    start_load();
    load_words(8'h10, 1'b0, 16);
  endtask

  task automatic test_collision();
    we    = 1'b1; waddr = 4'd7; wdata = 8'h77;
    rd_en = 1'b1; raddr = 4'd7;
    step();
    we    = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if (rdata !== 8'h17) $display("FAIL collide_old: got %h expected 17", rdata);
    else n_pass++;
    do_read(4'd7);
    n_checks++;
    if (rdata !== 8'h77) $display("FAIL collide_new: got %h expected 77", rdata);
    else n_pass++;
    we = 1'b1; waddr = 4'd9; wdata = 8'h99;
    step();
    we = 1'b0;
    do_read(4'd9);
    n_checks++;
    if (rdata !== 8'h99) $display("FAIL user_write: got %h expected 99", rdata);
    else n_pass++;
    // A user write to an already-loaded address during a load is ignored.
    start_load();
    load_words(8'h20, 1'b0, 4);
    we = 1'b1; waddr = 4'd2; wdata = 8'h5A;
    load_words(8'h24, 1'b0, 1);
    we = 1'b0;
    load_words(8'h25, 1'b0, 11);
    n_checks++;
    if (cfg_done !== 1'b1) $display("FAIL load2_done: got %b expected 1", cfg_done);
    else n_pass++;
    do_read(4'd2);
    n_checks++;
    if (rdata !== 8'h22) $display("FAIL we_in_load: got %h expected 22", rdata);
    else n_pass++;
  endtask

`ifdef SRAM_CFG_PARITY_EN
  task automatic test_parity();
    do_read(4'd2);
    n_checks++;
    if (par_err !== 1'b0) $display("FAIL par_clean: got %b expected 0", par_err);
    else n_pass++;
    dut.mem[2][0] = ~dut.mem[2][0];
    do_read(4'd2);
    n_checks++;
    if (par_err !== 1'b1) $display("FAIL par_flip: got %b expected 1", par_err);
    else n_pass++;
    do_read(4'd3);
    n_checks++;
    if (par_err !== 1'b0) $display("FAIL par_other: got %b expected 0", par_err);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_full_load();
    test_gaps();
    test_restart();
    test_reset_mid_load();
    test_collision();
`ifdef SRAM_CFG_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_cfg_bank.md
Name: sram_cfg_bank

Overview:
Parametrised configuration SRAM bank for the FPGA fabric, successor to the single-port-write/async-read LUT SRAM. It adds a sequential bitstream load engine with auto-increment addressing and a valid/ready handshake, and a registered read port with enable. It also adds a post-load user write port and read-first collision semantics. It sits between the bitstream loader and LUT/routing configuration consumers.

Parameters:
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words.
DATA_WIDTH, 1, bits per word.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  synchronous active-low reset.
cfg_start  in  1  pulse; begin (or restart) a full load at address 0.
cfg_valid  in  1  cfg_data valid.
cfg_data  in  DATA_WIDTH  bitstream word.
cfg_ready  out  1  bank accepts a cfg word this cycle.
cfg_done  out  1  level; bank fully loaded, run mode.
raddr  in  ADDR_WIDTH  read address.
rd_en  in  1  read enable.
rdata  out  DATA_WIDTH  registered read data.
waddr  in  ADDR_WIDTH  user write address.
wdata  in  DATA_WIDTH  user write data.
we  in  1  user write enable.

Behaviour:
- Reset: clk with rst_n=0 -> state IDLE, load counter 0, cfg_ready=0, cfg_done=0, rdata=0. Memory array is not cleared. Reset mid-load abandons the load; words already written remain but cfg_done stays 0.
- FSM states: IDLE, LOAD, RUN.
- IDLE -> LOAD on cfg_start. RUN -> LOAD on cfg_start; cfg_done drops the next cycle.
- In LOAD, cfg_start restarts the load: counter returns to 0, and any word presented that same cycle is dropped.
- LOAD: cfg_ready=1 (registered, asserted the cycle after entry). A handshake (cfg_valid & cfg_ready) writes cfg_data to mem[counter] and increments the counter.
- Accepting word DEPTH-1 moves the FSM to RUN. The counter wraps to 0. cfg_ready=0 and cfg_done=1 from the next cycle.
- cfg_valid without cfg_ready is ignored; there is no backpressure stall other than ready low.
- RUN: cfg_ready=0, cfg_done=1. User write: if we=1, mem[waddr] <= wdata at the edge.
- User writes are ignored in IDLE and LOAD; the loader owns the array during load.
- Read: if rd_en=1 in RUN, rdata <= mem[raddr] at the edge (1-cycle latency). If rd_en=0, or the state is not RUN, rdata holds its value.
- Collision (RUN, we & rd_en, raddr==waddr): read-first; rdata gets the old contents, and the new value is visible on the next read.
- Address range: all addresses 0..DEPTH-1 are valid; there is no out-of-range condition.

Optional Feature:
SRAM_CFG_PARITY_EN. When defined:
- Each word stores an extra even-parity bit computed on write (both load and user writes).
- Extra output port par_err (1 bit) is registered alongside rdata. It is 1 when the stored parity mismatches the read word, updates only when rdata updates, and resets to 0.
When undefined:
- No parity storage and no par_err port.
- Behaviour is otherwise identical.

Test Plan:
- Reset then idle (ADDR_WIDTH=4, DATA_WIDTH=8): rst_n=0 for 2 clks -> cfg_ready=0, cfg_done=0, rdata=0x00. rd_en=1 with raddr=3 in IDLE -> rdata stays 0x00.
- Full load: cfg_start, then 16 words 0x10..0x1F with cfg_valid held high -> cfg_done=1 one cycle after the 16th accept. Then rd_en with raddr=5 -> rdata=0x15 one cycle later.
- Handshake gaps: same load with cfg_valid low on alternate cycles -> all 16 words land at correct addresses, and cfg_done asserts only after the 16th accept. Reads 0..15 return 0x10..0x1F.
- Restart and reset mid-load: cfg_start, 6 words, cfg_start again, then 16 words 0xA0..0xAF -> mem[0]=0xA0 and mem[15]=0xAF. Separately, rst_n=0 after 8 words -> cfg_done=0 and state IDLE.
- Run-mode collision: in RUN with mem[7]=0x17, we=1, waddr=7, wdata=0x77, rd_en=1, raddr=7 -> rdata=0x17. The next read of 7 -> 0x77. we in LOAD -> no effect.
- Parity (SRAM_CFG_PARITY_EN): load, then force-flip one data bit of mem[2] via hierarchical access and read 2 -> par_err=1. Read 3 -> par_err=0.
